// File: rtl/usb11_utmi_tx.sv
// USB 1.1 UTMI transmit path: SYNC, bit-stuffed NRZI payload, then EOP.
// Full/low speed is picked per packet from utmi_xcvrselect_i.
module usb11_utmi_tx #(
  parameter int CLKS_PER_FS_BIT = 4,
  parameter int CLKS_PER_LS_BIT = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] utmi_xcvrselect_i,
  input  logic [7:0] utmi_data_i,
  input  logic       utmi_txvalid_i,
  output logic       utmi_txready_o,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe_o,
  output logic       tx_busy_o
);
  localparam int MAXN = (CLKS_PER_LS_BIT > CLKS_PER_FS_BIT) ? CLKS_PER_LS_BIT : CLKS_PER_FS_BIT;
  localparam int TW   = $clog2(MAXN) + 1;
  localparam logic [TW-1:0] FS_RELOAD = TW'(CLKS_PER_FS_BIT - 1);
  localparam logic [TW-1:0] LS_RELOAD = TW'(CLKS_PER_LS_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state_q, state_d;
  logic          ls_q, ls_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [2:0]    ones_q, ones_d;
  logic          stuff_q, stuff_d;
  logic          lvl_q, lvl_d;      // line level before the current symbol, 1 = J
  logic          eop_q, eop_d;

  logic          tick, sym, need_stuff, txready, line_j, se0;
  logic [TW-1:0] reload;

  assign tick   = (timer_q == '0);
  assign reload = ls_q ? LS_RELOAD : FS_RELOAD;
  // NRZI: a 0 bit (or a stuffed bit) toggles the line, a 1 holds it
  assign sym    = (stuff_q || !shift_q[0]) ? ~lvl_q : lvl_q;
  // stuff count runs on payload bits only; SYNC leaves it clear
  assign need_stuff = (state_q == DATA) && !stuff_q && shift_q[0] && (ones_q == 3'd5);

  always_comb begin
    state_d  = state_q;
    ls_d     = ls_q;
    timer_d  = timer_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    ones_d   = ones_q;
    stuff_d  = stuff_q;
    lvl_d    = lvl_q;
    eop_d    = eop_q;
    txready  = 1'b0;
    if (state_q != IDLE) timer_d = tick ? reload : timer_q - TW'(1);
    unique case (state_q)
      IDLE: begin
        if (utmi_txvalid_i) begin
          ls_d     = (utmi_xcvrselect_i == 2'b10);
          timer_d  = ls_d ? LS_RELOAD : FS_RELOAD;
          shift_d  = 8'h80;
          bitcnt_d = 3'd0;
          ones_d   = 3'd0;
          stuff_d  = 1'b0;
          lvl_d    = 1'b1;
          eop_d    = 1'b0;
          state_d  = SYNC;
        end
      end
      SYNC, DATA: begin
        if (tick) begin
          lvl_d = sym;
          if (stuff_q) begin
            stuff_d = 1'b0;
          end else if (state_q == DATA) begin
            if (!shift_q[0]) ones_d = 3'd0;
            else if (need_stuff) begin
              ones_d  = 3'd0;
              stuff_d = 1'b1;
            end else ones_d = ones_q + 3'd1;
          end
          // a pending stuff bit holds the bit pointer, so fetch waits for it
          if (!need_stuff) begin
            if (bitcnt_q == 3'd7) begin
              if (utmi_txvalid_i) begin
                shift_d  = utmi_data_i;
                bitcnt_d = 3'd0;
                txready  = 1'b1;
                state_d  = DATA;
              end else begin
                eop_d   = 1'b0;
                state_d = EOP_SE0;
              end
            end else begin
              shift_d  = {1'b0, shift_q[7:1]};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
      end
      EOP_SE0: begin
        if (tick) begin
          if (eop_q) state_d = EOP_J;
          else eop_d = 1'b1;
        end
      end
      EOP_J: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ls_q     <= 1'b0;
      timer_q  <= '0;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      ones_q   <= 3'd0;
      stuff_q  <= 1'b0;
      lvl_q    <= 1'b1;
      eop_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ls_q     <= ls_d;
      timer_q  <= timer_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ones_q   <= ones_d;
      stuff_q  <= stuff_d;
      lvl_q    <= lvl_d;
      eop_q    <= eop_d;
    end
  end

  always_comb begin
    line_j = 1'b1;
    if (state_q == SYNC || state_q == DATA) line_j = sym;
    se0 = (state_q == EOP_SE0);
  end

  // low speed swaps the J/K polarity of the pair
  assign usb_dp_o       = se0 ? 1'b0 : (line_j ^ ls_q);
  assign usb_dn_o       = se0 ? 1'b0 : ~(line_j ^ ls_q);
  assign usb_oe_o       = (state_q != IDLE);
  assign tx_busy_o      = (state_q != IDLE);
  assign utmi_txready_o = txready;
endmodule
